// File: rtl/sm83_alu_pkg.sv
// sm83_alu_pkg
// Shared definitions for the SM83 ALU stage:
//   alu_op_e  - 5-bit opcode encoding; codes above DAA are undefined
//   flags_t   - packed F register {Z,N,H,C}
//   FLAG_*    - bit positions of each flag inside the 4-bit F vector
//   is_zero   - Z flag helper
package sm83_alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_ADC  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SBC  = 5'd3,
    ALU_CP   = 5'd4,
    ALU_AND  = 5'd5,
    ALU_OR   = 5'd6,
    ALU_XOR  = 5'd7,
    ALU_INC  = 5'd8,
    ALU_DEC  = 5'd9,
    ALU_RLC  = 5'd10,
    ALU_RRC  = 5'd11,
    ALU_RL   = 5'd12,
    ALU_RR   = 5'd13,
    ALU_SLA  = 5'd14,
    ALU_SRA  = 5'd15,
    ALU_SRL  = 5'd16,
    ALU_SWAP = 5'd17,
    ALU_BIT  = 5'd18,
    ALU_SET  = 5'd19,
    ALU_RES  = 5'd20,
    ALU_CPL  = 5'd21,
    ALU_SCF  = 5'd22,
    ALU_CCF  = 5'd23,
    ALU_DAA  = 5'd24
  } alu_op_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  function automatic logic is_zero(input logic [7:0] v);
    return (v == 8'h00);
  endfunction

endpackage

// File: rtl/sm83_alu_core.sv
// sm83_alu_core
// Purely combinational SM83 datapath: computes the result, the next F value
// and the destination write enable for one opcode.
// Ports:
//   op_i       opcode (alu_op_e)
//   a_i, b_i   operands (A = accumulator)
//   bit_idx_i  bit index for BIT/SET/RES
//   flags_i    current F register (carry-in source)
//   result_o   computed result
//   flags_o    next F value
//   wr_en_o    destination write enable
// Optional feature: define ALU_DAA_EN to implement DAA; otherwise DAA is
// treated like an undefined opcode.
import sm83_alu_pkg::*;

module sm83_alu_core (
  input  alu_op_e      op_i,
  input  logic [7:0]   a_i,
  input  logic [7:0]   b_i,
  input  logic [2:0]   bit_idx_i,
  input  flags_t       flags_i,
  output logic [7:0]   result_o,
  output flags_t       flags_o,
  output logic         wr_en_o
);

  logic       cin_add_s;
  logic       cin_sub_s;
  logic [8:0] add_s;
  logic [4:0] add_lo_s;
  logic [8:0] sub_s;
  logic [4:0] sub_lo_s;

  // Carry-in is only honoured by the "with carry" forms.
  assign cin_add_s = (op_i == ALU_ADC) && flags_i.c;
  assign cin_sub_s = (op_i == ALU_SBC) && flags_i.c;

  // 9-bit sums; bit 8 is carry/borrow out, the 5-bit nibble sum gives H.
  assign add_s    = {1'b0, a_i} + {1'b0, b_i} + {8'd0, cin_add_s};
  assign add_lo_s = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'd0, cin_add_s};
  assign sub_s    = {1'b0, a_i} - {1'b0, b_i} - {8'd0, cin_sub_s};
  assign sub_lo_s = {1'b0, a_i[3:0]} - {1'b0, b_i[3:0]} - {4'd0, cin_sub_s};

`ifdef ALU_DAA_EN
  logic       daa_lo_s;
  logic       daa_hi_s;
  logic [7:0] daa_corr_s;
  logic [7:0] daa_res_s;

  // In the subtract direction only H and C select a correction; the
  // add direction also corrects out-of-range BCD digits.
  assign daa_lo_s   = flags_i.h || (!flags_i.n && (a_i[3:0] > 4'h9));
  assign daa_hi_s   = flags_i.c || (!flags_i.n && (a_i > 8'h99));
  assign daa_corr_s = {1'b0, daa_hi_s, daa_hi_s, 1'b0, 1'b0, daa_lo_s, daa_lo_s, 1'b0};
  assign daa_res_s  = flags_i.n ? (a_i - daa_corr_s) : (a_i + daa_corr_s);
`endif

  // Opcode decode: default leaves A and F untouched with no write.
  always_comb begin
    result_o = a_i;
    flags_o  = flags_i;
    wr_en_o  = 1'b0;
    case (op_i)
      ALU_ADD, ALU_ADC: begin
        result_o = add_s[7:0];
        wr_en_o  = 1'b1;
        flags_o  = '{z: is_zero(add_s[7:0]), n: 1'b0, h: add_lo_s[4], c: add_s[8]};
      end
      ALU_SUB, ALU_SBC: begin
        result_o = sub_s[7:0];
        wr_en_o  = 1'b1;
        flags_o  = '{z: is_zero(sub_s[7:0]), n: 1'b1, h: sub_lo_s[4], c: sub_s[8]};
      end
      ALU_CP: begin
        flags_o  = '{z: is_zero(sub_s[7:0]), n: 1'b1, h: sub_lo_s[4], c: sub_s[8]};
      end
      ALU_AND: begin
        result_o = a_i & b_i;
        wr_en_o  = 1'b1;
        flags_o  = '{z: is_zero(a_i & b_i), n: 1'b0, h: 1'b1, c: 1'b0};
      end
      ALU_OR: begin
        result_o = a_i | b_i;
        wr_en_o  = 1'b1;
        flags_o  = '{z: is_zero(a_i | b_i), n: 1'b0, h: 1'b0, c: 1'b0};
      end
      ALU_XOR: begin
        result_o = a_i ^ b_i;
        wr_en_o  = 1'b1;
        flags_o  = '{z: is_zero(a_i ^ b_i), n: 1'b0, h: 1'b0, c: 1'b0};
      end
      ALU_INC: begin
        result_o  = b_i + 8'd1;
        wr_en_o   = 1'b1;
        flags_o.z = is_zero(b_i + 8'd1);
        flags_o.n = 1'b0;
        flags_o.h = (b_i[3:0] == 4'hF);
      end
      ALU_DEC: begin
        result_o  = b_i - 8'd1;
        wr_en_o   = 1'b1;
        flags_o.z = is_zero(b_i - 8'd1);
        flags_o.n = 1'b1;
        flags_o.h = (b_i[3:0] == 4'h0);
      end
      ALU_RLC, ALU_RRC, ALU_RL, ALU_RR, ALU_SLA, ALU_SRA, ALU_SRL, ALU_SWAP: begin
        wr_en_o   = 1'b1;
        flags_o.n = 1'b0;
        flags_o.h = 1'b0;
        case (op_i)
          ALU_RLC: begin result_o = {b_i[6:0], b_i[7]};     flags_o.c = b_i[7]; end
          ALU_RRC: begin result_o = {b_i[0], b_i[7:1]};     flags_o.c = b_i[0]; end
          ALU_RL:  begin result_o = {b_i[6:0], flags_i.c};  flags_o.c = b_i[7]; end
          ALU_RR:  begin result_o = {flags_i.c, b_i[7:1]};  flags_o.c = b_i[0]; end
          ALU_SLA: begin result_o = {b_i[6:0], 1'b0};       flags_o.c = b_i[7]; end
          ALU_SRA: begin result_o = {b_i[7], b_i[7:1]};     flags_o.c = b_i[0]; end
          ALU_SRL: begin result_o = {1'b0, b_i[7:1]};       flags_o.c = b_i[0]; end
          default: begin result_o = {b_i[3:0], b_i[7:4]};   flags_o.c = 1'b0;   end
        endcase
        flags_o.z = is_zero(result_o);
      end
      ALU_BIT: begin
        flags_o.z = !b_i[bit_idx_i];
        flags_o.n = 1'b0;
        flags_o.h = 1'b1;
      end
      ALU_SET: begin
        result_o            = b_i;
        result_o[bit_idx_i] = 1'b1;
        wr_en_o             = 1'b1;
      end
      ALU_RES: begin
        result_o            = b_i;
        result_o[bit_idx_i] = 1'b0;
        wr_en_o             = 1'b1;
      end
      ALU_CPL: begin
        result_o  = ~a_i;
        wr_en_o   = 1'b1;
        flags_o.n = 1'b1;
        flags_o.h = 1'b1;
      end
      ALU_SCF: begin
        flags_o.n = 1'b0;
        flags_o.h = 1'b0;
        flags_o.c = 1'b1;
      end
      ALU_CCF: begin
        flags_o.n = 1'b0;
        flags_o.h = 1'b0;
        flags_o.c = !flags_i.c;
      end
`ifdef ALU_DAA_EN
      ALU_DAA: begin
        result_o  = daa_res_s;
        wr_en_o   = 1'b1;
        flags_o.z = is_zero(daa_res_s);
        flags_o.h = 1'b0;
        flags_o.c = daa_hi_s;
      end
`endif
      default: begin
        result_o = a_i;
        flags_o  = flags_i;
        wr_en_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sm83_alu_stage.sv
// sm83_alu_stage
// SM83 ALU stage feeding the accumulator: one-cycle registered result with a
// valid/ready handshake, and owner of the F (ZNHC) flag register.
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   op_valid_i / op_ready_o   operation request handshake
//   op_i, a_i, b_i, bit_idx_i operation and operands
//   res_valid_o / res_ready_i result handshake
//   result_o, wr_en_o         registered result and destination write enable
//   flags_o                   F register {Z,N,H,C}
//   flags_wr_i, flags_din_i   direct F load (POP AF), wins over an accept
// Optional feature: macro ALU_DAA_EN enables the DAA opcode.
import sm83_alu_pkg::*;

module sm83_alu_stage #(
  parameter logic [3:0] FLAG_RST = 4'h0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       op_valid_i,
  output logic       op_ready_o,
  input  logic [4:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] bit_idx_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [7:0] result_o,
  output logic       wr_en_o,
  output logic [3:0] flags_o,
  input  logic       flags_wr_i,
  input  logic [3:0] flags_din_i
);

  logic       res_valid_r;
  logic [7:0] result_r;
  logic       wr_en_r;
  flags_t     flags_r;

  logic       accept_s;
  logic [7:0] core_result_s;
  flags_t     core_flags_s;
  logic       core_wr_en_s;

  sm83_alu_core u_core (
    .op_i      (alu_op_e'(op_i)),
    .a_i       (a_i),
    .b_i       (b_i),
    .bit_idx_i (bit_idx_i),
    .flags_i   (flags_r),
    .result_o  (core_result_s),
    .flags_o   (core_flags_s),
    .wr_en_o   (core_wr_en_s)
  );

  assign op_ready_o  = !res_valid_r || res_ready_i;
  assign accept_s    = op_valid_i && op_ready_o;

  assign res_valid_o = res_valid_r;
  assign result_o    = result_r;
  assign wr_en_o     = wr_en_r;
  assign flags_o     = flags_r;

  // Output register and F register; a direct F load overrides the op's flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_valid_r <= 1'b0;
      result_r    <= 8'h00;
      wr_en_r     <= 1'b0;
      flags_r     <= flags_t'(FLAG_RST);
    end else begin
      if (accept_s) begin
        res_valid_r <= 1'b1;
        result_r    <= core_result_s;
        wr_en_r     <= core_wr_en_s;
      end else if (res_ready_i) begin
        res_valid_r <= 1'b0;
      end

      if (flags_wr_i) begin
        flags_r <= flags_t'(flags_din_i);
      end else if (accept_s) begin
        flags_r <= core_flags_s;
      end
    end
  end

endmodule

// File: tb/tb_sm83_alu_stage.sv
// tb_sm83_alu_stage
// Directed self-checking bench for sm83_alu_stage. Expected results are
// queued when an operation is accepted and compared when the result appears.
// Honours ALU_DAA_EN the same way as the design.
import sm83_alu_pkg::*;

module tb_sm83_alu_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [4:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] idx;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       wr_en;
  logic [3:0] flags;
  logic       flags_wr;
  logic [3:0] flags_din;

  typedef struct packed {
    logic [7:0] res;
    logic       wr;
    logic [3:0] fl;
    logic       chk_res;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  sm83_alu_stage #(.FLAG_RST(4'h0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .bit_idx_i   (idx),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .result_o    (result),
    .wr_en_o     (wr_en),
    .flags_o     (flags),
    .flags_wr_i  (flags_wr),
    .flags_din_i (flags_din)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive an op (held valid), record its expectation, advance past the edge.
  task automatic issue(input logic [4:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] iv, input logic [7:0] er, input logic ew,
                       input logic [3:0] ef, input logic cr);
    op = o; a = av; b = bv; idx = iv; op_valid = 1'b1;
    chk("op_ready", {7'd0, op_ready}, 8'h01);
    exp_q.push_back('{res: er, wr: ew, fl: ef, chk_res: cr});
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".valid"}, {7'd0, res_valid}, 8'h01);
    if (exp_q.size() == 0) begin
      chk({tag, ".queue"}, 8'h00, 8'h01);
    end else begin
      e = exp_q.pop_front();
      if (e.chk_res) chk({tag, ".result"}, result, e.res);
      chk({tag, ".wr_en"}, {7'd0, wr_en}, {7'd0, e.wr});
      chk({tag, ".flags"}, {4'd0, flags}, {4'd0, e.fl});
    end
  endtask

  task automatic idle();
    op_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle.valid", {7'd0, res_valid}, 8'h00);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op = 5'd0; a = 8'h00; b = 8'h00; idx = 3'd0;
    res_ready = 1'b1; flags_wr = 1'b0; flags_din = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst.valid",  {7'd0, res_valid}, 8'h00);
    chk("rst.result", result, 8'h00);
    chk("rst.wr_en",  {7'd0, wr_en}, 8'h00);
    chk("rst.flags",  {4'd0, flags}, 8'h00);

    // Arithmetic, one-cycle latency
    issue(ALU_ADD, 8'h3A, 8'hC6, 3'd0, 8'h00, 1'b1, 4'hB, 1'b1); check_out("add");
    issue(ALU_CP,  8'h3C, 8'h40, 3'd0, 8'h00, 1'b0, 4'h5, 1'b0); check_out("cp");
    issue(ALU_SUB, 8'h3E, 8'h3E, 3'd0, 8'h00, 1'b1, 4'hC, 1'b1); check_out("sub");
    // Back-to-back: ADC picks up the carry SCF just set
    issue(ALU_SCF, 8'h12, 8'h00, 3'd0, 8'h00, 1'b0, 4'h9, 1'b0); check_out("scf");
    issue(ALU_ADC, 8'hE1, 8'h0F, 3'd0, 8'hF1, 1'b1, 4'h2, 1'b1); check_out("adc");

    // DAA
    issue(ALU_ADD, 8'h45, 8'h38, 3'd0, 8'h7D, 1'b1, 4'h0, 1'b1); check_out("add_bcd");
`ifdef ALU_DAA_EN
    issue(ALU_DAA, 8'h7D, 8'h00, 3'd0, 8'h83, 1'b1, 4'h0, 1'b1); check_out("daa");
`else
    issue(ALU_DAA, 8'h7D, 8'h00, 3'd0, 8'h7D, 1'b0, 4'h0, 1'b1); check_out("daa_off");
`endif

    // Backpressure
    issue(ALU_INC, 8'h00, 8'h0F, 3'd0, 8'h10, 1'b1, 4'h2, 1'b1); check_out("inc");
    op = ALU_DEC; b = 8'h10; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.ready",  {7'd0, op_ready}, 8'h00);
      chk("bp.valid",  {7'd0, res_valid}, 8'h01);
      chk("bp.result", result, 8'h10);
      chk("bp.flags",  {4'd0, flags}, 8'h02);
    end
    res_ready = 1'b1; #1;
    chk("bp.release", {7'd0, op_ready}, 8'h01);
    exp_q.push_back('{res: 8'h0F, wr: 1'b1, fl: 4'h6, chk_res: 1'b1});
    @(posedge clk); #1;
    check_out("dec");

    // Logic, shifts, bit ops, flag ops, undefined code
    issue(ALU_XOR,  8'h5A, 8'h5A, 3'd0, 8'h00, 1'b1, 4'h8, 1'b1); check_out("xor");
    issue(ALU_SWAP, 8'h00, 8'hF0, 3'd0, 8'h0F, 1'b1, 4'h0, 1'b1); check_out("swap");
    issue(ALU_RR,   8'h00, 8'h01, 3'd0, 8'h00, 1'b1, 4'h9, 1'b1); check_out("rr");
    issue(ALU_BIT,  8'h00, 8'h7F, 3'd7, 8'h00, 1'b0, 4'hB, 1'b0); check_out("bit");
    issue(ALU_SET,  8'h00, 8'h00, 3'd0, 8'h01, 1'b1, 4'hB, 1'b1); check_out("set");
    issue(ALU_CPL,  8'h35, 8'h00, 3'd0, 8'hCA, 1'b1, 4'hF, 1'b1); check_out("cpl");
    issue(ALU_CCF,  8'h35, 8'h00, 3'd0, 8'h00, 1'b0, 4'h8, 1'b0); check_out("ccf");
    issue(5'd31,    8'h77, 8'h00, 3'd0, 8'h77, 1'b0, 4'h8, 1'b1); check_out("undef");
    issue(ALU_SRA,  8'h00, 8'h81, 3'd0, 8'hC0, 1'b1, 4'h1, 1'b1); check_out("sra");
    idle();

    // Asynchronous reset while a result is held
    issue(ALU_ADD, 8'h01, 8'h01, 3'd0, 8'h02, 1'b1, 4'h0, 1'b1); check_out("pre_rst");
    op_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;
    chk("hold.valid", {7'd0, res_valid}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", {7'd0, res_valid}, 8'h00);
    chk("arst.flags", {4'd0, flags}, 8'h00);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0; res_ready = 1'b1;

    // Direct F load wins over the op's flags; result still produced
    flags_wr = 1'b1; flags_din = 4'hA;
    issue(ALU_AND, 8'hFF, 8'h0F, 3'd0, 8'h0F, 1'b1, 4'hA, 1'b1); check_out("and_fwr");
    op_valid = 1'b0; flags_din = 4'h5;
    @(posedge clk); #1;
    chk("fwr.flags", {4'd0, flags}, 8'h05);
    chk("fwr.valid", {7'd0, res_valid}, 8'h00);
    flags_wr = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
